fifo_bank4: RTL and testbench

Bank of four independent synchronous FIFOs sitting on both sides of the arbiter. Receives per-lane push strobes with one shared write bus and per-lane pop strobes. Returns per-lane empty, almost-full, full and error flags, plus four first-word-fall-through data outputs. It is the responder end of the arbiter's `fifos_push`/`fifos_pop` ↔ `fifos_empty`/`fifos_almost_full`/`fifo_data_inN` interface.

---
 rtl/fifo_bank4_pkg.sv | 10 +
 rtl/fifo_bank4_if.sv | 32 +++
 rtl/fifo_bank4_fifo_lane.sv | 88 ++++++++
 rtl/fifo_bank4.sv | 42 ++++
 tb/tb_fifo_bank4.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fifo_bank4_pkg.sv
// rtl/fifo_bank4_pkg.sv - shared defaults for the four-lane FIFO bank
package fifo_bank4_pkg;

    localparam int NUM_LANES          = 4;
    localparam int WORD_SIZE_DEF      = 12;
    localparam int DEPTH_DEF          = 8;
    localparam int PTR_WIDTH_DEF      = 3;
    localparam int ALMOST_FULL_TH_DEF = 6;

endpackage

// File: rtl/fifo_bank4_if.sv
// rtl/fifo_bank4_if.sv - push/pop/flag bundle between the arbiter and the FIFO bank
interface fifo_bank4_if
    import fifo_bank4_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
);

    logic [NUM_LANES-1:0] fifos_push;
    logic [WORD_SIZE-1:0] fifo_data_in;
    logic [NUM_LANES-1:0] fifos_pop;
    logic [WORD_SIZE-1:0] fifo_data_out0;
    logic [WORD_SIZE-1:0] fifo_data_out1;
    logic [WORD_SIZE-1:0] fifo_data_out2;
    logic [WORD_SIZE-1:0] fifo_data_out3;
    logic [NUM_LANES-1:0] fifos_empty;
    logic [NUM_LANES-1:0] fifos_almost_full;
    logic [NUM_LANES-1:0] fifos_full;
    logic [NUM_LANES-1:0] fifos_error;

    modport master (
        output fifos_push, fifo_data_in, fifos_pop,
        input  fifo_data_out0, fifo_data_out1, fifo_data_out2, fifo_data_out3,
        input  fifos_empty, fifos_almost_full, fifos_full, fifos_error
    );

    modport slave (
        input  fifos_push, fifo_data_in, fifos_pop,
        output fifo_data_out0, fifo_data_out1, fifo_data_out2, fifo_data_out3,
        output fifos_empty, fifos_almost_full, fifos_full, fifos_error
    );

endinterface

// File: rtl/fifo_bank4_fifo_lane.sv
// rtl/fifo_bank4_fifo_lane.sv - one first-word-fall-through FIFO lane with sticky error
module fifo_lane
    import fifo_bank4_pkg::*;
#(
    parameter int WORD_SIZE      = WORD_SIZE_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int PTR_WIDTH      = PTR_WIDTH_DEF,
    parameter int ALMOST_FULL_TH = ALMOST_FULL_TH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WORD_SIZE-1:0] data_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 full_o,
    output logic                 error_o
);

    localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   AF_CNT   = (PTR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 af_q, af_d;
    logic                 full_q, full_d;
    logic                 error_q, error_d;
    logic                 push_ok, pop_ok;

    // A full lane still takes a push when the same edge frees a slot.
    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q != FULL_CNT) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_CNT);
        full_d  = (count_d == FULL_CNT);
        error_d = error_q | (push_i & ~push_ok) | (pop_i & ~pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            full_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            full_q   <= full_d;
            error_q  <= error_d;
        end
    end

    // Storage is never reset; the empty mask keeps stale words invisible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o        = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty_o       = empty_q;
    assign almost_full_o = af_q;
    assign full_o        = full_q;
    assign error_o       = error_q;

endmodule

// File: rtl/fifo_bank4.sv
// rtl/fifo_bank4.sv - four independent FIFO lanes sharing one write bus
module fifo_bank4
    import fifo_bank4_pkg::*;
#(
    parameter int WORD_SIZE      = WORD_SIZE_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int PTR_WIDTH      = PTR_WIDTH_DEF,
    parameter int ALMOST_FULL_TH = ALMOST_FULL_TH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fifo_bank4_if.slave   bus
);

    logic [WORD_SIZE-1:0] lane_data [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        fifo_lane #(
            .WORD_SIZE      (WORD_SIZE),
            .DEPTH          (DEPTH),
            .PTR_WIDTH      (PTR_WIDTH),
            .ALMOST_FULL_TH (ALMOST_FULL_TH)
        ) u_lane (
            .clk           (clk),
            .rst_n         (reset),
            .push_i        (bus.fifos_push[i]),
            .pop_i         (bus.fifos_pop[i]),
            .data_i        (bus.fifo_data_in),
            .data_o        (lane_data[i]),
            .empty_o       (bus.fifos_empty[i]),
            .almost_full_o (bus.fifos_almost_full[i]),
            .full_o        (bus.fifos_full[i]),
            .error_o       (bus.fifos_error[i])
        );
    end

    assign bus.fifo_data_out0 = lane_data[0];
    assign bus.fifo_data_out1 = lane_data[1];
    assign bus.fifo_data_out2 = lane_data[2];
    assign bus.fifo_data_out3 = lane_data[3];

endmodule

// File: tb/tb_fifo_bank4.sv
// tb/tb_fifo_bank4.sv - directed table and sequence checks for fifo_bank4
module tb_fifo_bank4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fifo_bank4_if #(.WORD_SIZE(12)) bus ();

    fifo_bank4 u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  push;
        logic [3:0]  pop;
        logic [11:0] din;
        logic [3:0]  e_empty;
        logic [3:0]  e_af;
        logic [3:0]  e_full;
        logic [3:0]  e_err;
        logic [11:0] e_d0;
        logic [11:0] e_d1;
        logic [11:0] e_d2;
        logic [11:0] e_d3;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_empty, input logic [3:0] e_af,
                           input logic [3:0] e_full, input logic [3:0] e_err,
                           input logic [11:0] d0, input logic [11:0] d1,
                           input logic [11:0] d2, input logic [11:0] d3);
        chk({tag, " empty"}, 32'(bus.fifos_empty), 32'(e_empty));
        chk({tag, " afull"}, 32'(bus.fifos_almost_full), 32'(e_af));
        chk({tag, " full"},  32'(bus.fifos_full), 32'(e_full));
        chk({tag, " error"}, 32'(bus.fifos_error), 32'(e_err));
        chk({tag, " dout0"}, 32'(bus.fifo_data_out0), 32'(d0));
        chk({tag, " dout1"}, 32'(bus.fifo_data_out1), 32'(d1));
        chk({tag, " dout2"}, 32'(bus.fifo_data_out2), 32'(d2));
        chk({tag, " dout3"}, 32'(bus.fifo_data_out3), 32'(d3));
    endtask

    task automatic step(input logic [3:0] push, input logic [3:0] pop, input logic [11:0] din);
        bus.fifos_push   = push;
        bus.fifos_pop    = pop;
        bus.fifo_data_in = din;
        @(posedge clk);
        #1;
        bus.fifos_push = 4'b0000;
        bus.fifos_pop  = 4'b0000;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.fifos_push   = 4'b0000;
        bus.fifos_pop    = 4'b0000;
        bus.fifo_data_in = 12'h000;

        // lane 0: three words in, three out
        vecs[0]  = '{4'b0001, 4'b0000, 12'h34C, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 12'h34C, 12'h000, 12'h000, 12'h000};
        vecs[1]  = '{4'b0001, 4'b0000, 12'hACC, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 12'h34C, 12'h000, 12'h000, 12'h000};
        vecs[2]  = '{4'b0001, 4'b0000, 12'hB4C, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 12'h34C, 12'h000, 12'h000, 12'h000};
        vecs[3]  = '{4'b0000, 4'b0001, 12'h000, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 12'hACC, 12'h000, 12'h000, 12'h000};
        vecs[4]  = '{4'b0000, 4'b0001, 12'h000, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 12'hB4C, 12'h000, 12'h000, 12'h000};
        vecs[5]  = '{4'b0000, 4'b0001, 12'h000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 12'h000, 12'h000, 12'h000, 12'h000};
        // lane 1: fill past almost-full to full, then overflow
        vecs[6]  = '{4'b0010, 4'b0000, 12'h101, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 12'h000, 12'h101, 12'h000, 12'h000};
        vecs[7]  = '{4'b0010, 4'b0000, 12'h102, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 12'h000, 12'h101, 12'h000, 12'h000};
        vecs[8]  = '{4'b0010, 4'b0000, 12'h103, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 12'h000, 12'h101, 12'h000, 12'h000};
        vecs[9]  = '{4'b0010, 4'b0000, 12'h104, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 12'h000, 12'h101, 12'h000, 12'h000};
        vecs[10] = '{4'b0010, 4'b0000, 12'h105, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 12'h000, 12'h101, 12'h000, 12'h000};
        vecs[11] = '{4'b0010, 4'b0000, 12'h106, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 12'h000, 12'h101, 12'h000, 12'h000};
        vecs[12] = '{4'b0010, 4'b0000, 12'h107, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 12'h000, 12'h101, 12'h000, 12'h000};
        vecs[13] = '{4'b0010, 4'b0000, 12'h108, 4'b1101, 4'b0010, 4'b0010, 4'b0000, 12'h000, 12'h101, 12'h000, 12'h000};
        vecs[14] = '{4'b0010, 4'b0000, 12'h109, 4'b1101, 4'b0010, 4'b0010, 4'b0010, 12'h000, 12'h101, 12'h000, 12'h000};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all("reset", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 12'h000, 12'h000, 12'h000, 12'h000);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_af, vecs[i].e_full,
                    vecs[i].e_err, vecs[i].e_d0, vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_d3);
        end

        // drain lane 1: the overflowed word 12'h109 must never appear
        for (int k = 1; k <= 8; k++) begin
            step(4'b0000, 4'b0010, 12'h000);
            chk($sformatf("drain1 dout1 %0d", k), 32'(bus.fifo_data_out1),
                (k == 8) ? 32'h0 : 32'h101 + 32'(k));
            chk($sformatf("drain1 afull %0d", k), 32'(bus.fifos_almost_full[1]), (k <= 2) ? 32'd1 : 32'd0);
            chk($sformatf("drain1 full %0d", k), 32'(bus.fifos_full[1]), 32'd0);
        end
        chk("drain1 empty", 32'(bus.fifos_empty), 32'hF);

        // lane 2: fill, then simultaneous push and pop while full
        for (int k = 0; k < 8; k++) begin
            step(4'b0100, 4'b0000, 12'h201 + 12'(k));
            chk($sformatf("fill2 full %0d", k), 32'(bus.fifos_full), (k == 7) ? 32'h4 : 32'h0);
        end
        step(4'b0100, 4'b0100, 12'hEED);
        chk_all("pushpop full", 4'b1011, 4'b0100, 4'b0100, 4'b0010, 12'h000, 12'h000, 12'h202, 12'h000);
        for (int k = 1; k <= 8; k++) begin
            step(4'b0000, 4'b0100, 12'h000);
            chk($sformatf("drain2 dout2 %0d", k), 32'(bus.fifo_data_out2),
                (k <= 6) ? 32'h202 + 32'(k) : ((k == 7) ? 32'hEED : 32'h0));
        end
        chk("drain2 empty", 32'(bus.fifos_empty), 32'hF);
        chk("drain2 error", 32'(bus.fifos_error), 32'h2);

        // lane 3: pop on empty with a concurrent push
        step(4'b1000, 4'b1000, 12'hF0F);
        chk_all("underflow push", 4'b0111, 4'b0000, 4'b0000, 4'b1010, 12'h000, 12'h000, 12'h000, 12'hF0F);
        step(4'b0000, 4'b1000, 12'h000);
        chk("pop3 empty", 32'(bus.fifos_empty), 32'hF);

        // broadcast write, then asynchronous reset between edges
        step(4'b1111, 4'b0000, 12'h2CF);
        chk_all("broadcast", 4'b0000, 4'b0000, 4'b0000, 4'b1010, 12'h2CF, 12'h2CF, 12'h2CF, 12'h2CF);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async reset", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 12'h000, 12'h000, 12'h000, 12'h000);
        @(negedge clk);
        reset = 1'b1;
        step(4'b0000, 4'b0000, 12'h000);
        chk_all("post reset", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 12'h000, 12'h000, 12'h000, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
